// File: rtl/mps_adc_intl_monitor.sv
// Per-channel ADC limit monitor with debounced, latched interlock flags and an OR'd trip output.
// Optional first-fault capture is built when MPS_INTL_FIRST_FAULT_EN is defined.
module mps_adc_intl_monitor #(
  parameter  int NUM_CH   = 8,
  parameter  int DATA_W   = 32,
  parameter  int DEBOUNCE = 4,
  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH*DATA_W-1:0] i_hi_lim,
  input  logic [NUM_CH*DATA_W-1:0] i_lo_lim,
  input  logic [NUM_CH-1:0]        i_ch_en,
  input  logic                     i_intl_clr,
  output logic [NUM_CH-1:0]        o_intl_flag,
  output logic                     o_intl,
  output logic [NUM_CH-1:0]        o_over,
  output logic [IDX_W-1:0]         o_first_ch,
  output logic                     o_first_valid
);

  typedef enum logic [1:0] {ST_ARMED, ST_COUNT, ST_TRIPPED} state_e;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  state_e            state_q [NUM_CH];
  logic [7:0]        cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] flag_q;
  logic [NUM_CH-1:0] over_q;
  logic [NUM_CH-1:0] viol;
  logic [NUM_CH-1:0] trip;

  // Equality with either limit counts as in range; lo > hi makes every sample a violation.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
    logic signed [DATA_W-1:0] d_s, hi_s, lo_s;
    assign d_s     = i_data[k*DATA_W +: DATA_W];
    assign hi_s    = i_hi_lim[k*DATA_W +: DATA_W];
    assign lo_s    = i_lo_lim[k*DATA_W +: DATA_W];
    assign viol[k] = (d_s > hi_s) || (d_s < lo_s);
  end

  // trip[k]: this edge samples the DEBOUNCE-th consecutive violation of channel k.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    trip = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_sample_valid[k] && i_ch_en[k] && viol[k] && !i_intl_clr) begin
        case (state_q[k])
          ST_ARMED: trip[k] = (DEBOUNCE == 1);
          ST_COUNT: trip[k] = (cnt_q[k] == CNT_LAST);
          default:  trip[k] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= ST_ARMED;
        cnt_q[k]   <= '0;
      end
      flag_q <= '0;
      over_q <= '0;
    end else if (i_intl_clr) begin
      // Clear discards this cycle's samples, so o_over is left untouched as well.
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= ST_ARMED;
        cnt_q[k]   <= '0;
      end
      flag_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!i_ch_en[k]) begin
          state_q[k] <= ST_ARMED;
          cnt_q[k]   <= '0;
        end else if (i_sample_valid[k]) begin
          over_q[k] <= viol[k];
          case (state_q[k])
            ST_ARMED: if (viol[k]) begin
              cnt_q[k]   <= 8'd1;
              state_q[k] <= trip[k] ? ST_TRIPPED : ST_COUNT;
            end
            ST_COUNT: if (viol[k]) begin
              cnt_q[k]   <= cnt_q[k] + 8'd1;
              state_q[k] <= trip[k] ? ST_TRIPPED : ST_COUNT;
            end else begin
              cnt_q[k]   <= '0;
              state_q[k] <= ST_ARMED;
            end
            default: ;
          endcase
        end
      end
      flag_q <= flag_q | trip;
    end
  end

  assign o_intl_flag = flag_q;
  assign o_intl      = |flag_q;
  assign o_over      = over_q;

`ifdef MPS_INTL_FIRST_FAULT_EN
  logic [NUM_CH-1:0] rise;
  logic [IDX_W-1:0]  rise_idx;
  logic [IDX_W-1:0]  first_ch_q;
  logic              first_valid_q;

  assign rise = trip & ~flag_q;

  // Scan downward so the lowest rising index wins.
  always_comb begin
    rise_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rise[k]) rise_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_intl_clr) begin
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
    end else if (!first_valid_q && (|rise)) begin
      first_ch_q    <= rise_idx;
      first_valid_q <= 1'b1;
    end
  end

  assign o_first_ch    = first_ch_q;
  assign o_first_valid = first_valid_q;
`else
  assign o_first_ch    = '0;
  assign o_first_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mps_adc_intl_monitor.sv
// Scoreboard bench for mps_adc_intl_monitor: a small reference model pushes expected outputs per
// driven cycle; each test pops and compares after the clock edge.
module tb_mps_adc_intl_monitor;

  localparam int NUM_CH   = 8;
  localparam int DATA_W   = 32;
  localparam int DEBOUNCE = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        sample_valid;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH*DATA_W-1:0] hi_lim;
  logic [NUM_CH*DATA_W-1:0] lo_lim;
  logic [NUM_CH-1:0]        ch_en;
  logic                     intl_clr;
  logic [NUM_CH-1:0]        intl_flag;
  logic                     intl;
  logic [NUM_CH-1:0]        over;
  logic [2:0]               first_ch;
  logic                     first_valid;

  always #5 clk = ~clk;

  mps_adc_intl_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE(DEBOUNCE)) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(sample_valid), .i_data(data),
    .i_hi_lim(hi_lim), .i_lo_lim(lo_lim), .i_ch_en(ch_en), .i_intl_clr(intl_clr),
    .o_intl_flag(intl_flag), .o_intl(intl), .o_over(over),
    .o_first_ch(first_ch), .o_first_valid(first_valid)
  );

  typedef struct packed {
    logic [7:0] flag;
    logic [7:0] over;
    logic       intl;
    logic       fv;
    logic [2:0] fch;
  } exp_t;

  typedef struct {
    logic [7:0] mask;
    int         value;
    logic       clr;
  } step_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  int         m_cnt  [NUM_CH];
  bit         m_trip [NUM_CH];
  logic [7:0] m_flag;
  logic [7:0] m_over;
  logic       m_fv;
  logic [2:0] m_fch;

  function automatic bit out_of_range(input int k, input int v);
    int h, l;
    h = hi_lim[k*DATA_W +: DATA_W];
    l = lo_lim[k*DATA_W +: DATA_W];
    return (v > h) || (v < l);
  endfunction

  function automatic exp_t act_now();
    return {intl_flag, over, intl, first_valid, first_ch};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_cnt[k]  = 0;
      m_trip[k] = 0;
    end
    m_flag = '0;
    m_over = '0;
    m_fv   = 1'b0;
    m_fch  = '0;
    sb.delete();
  endtask

  // Drive one cycle, advance the model, push its expectation, and step past the edge.
  task automatic apply(input step_t s);
    logic [7:0] rise;
    rise = '0;
    sample_valid = s.mask;
    intl_clr     = s.clr;
    for (int k = 0; k < NUM_CH; k++) data[k*DATA_W +: DATA_W] = s.value;
    if (s.clr) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_cnt[k]  = 0;
        m_trip[k] = 0;
      end
      m_flag = '0;
      m_fv   = 1'b0;
      m_fch  = '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!ch_en[k]) begin
          m_cnt[k]  = 0;
          m_trip[k] = 0;
        end else if (s.mask[k]) begin
          m_over[k] = out_of_range(k, s.value);
          if (!m_trip[k]) begin
            if (m_over[k]) begin
              m_cnt[k]++;
              if (m_cnt[k] == DEBOUNCE) begin
                m_trip[k] = 1;
                rise[k]   = 1'b1;
              end
            end else begin
              m_cnt[k] = 0;
            end
          end
        end
      end
      rise = rise & ~m_flag;
`ifdef MPS_INTL_FIRST_FAULT_EN
      if (!m_fv && rise != 0) begin
        m_fv = 1'b1;
        for (int k = NUM_CH - 1; k >= 0; k--) if (rise[k]) m_fch = 3'(k);
      end
`endif
      m_flag = m_flag | rise;
    end
    sb.push_back({m_flag, m_over, |m_flag, m_fv, m_fch});
    @(posedge clk);
    #1;
    sample_valid = '0;
    intl_clr     = 1'b0;
  endtask

  function automatic step_t st(input logic [7:0] mask, input int value, input logic clr = 1'b0);
    step_t s;
    s.mask  = mask;
    s.value = value;
    s.clr   = clr;
    return s;
  endfunction

  task automatic test_reset();
    exp_t a;
    rst          = 1'b1;
    sample_valid = '1;
    for (int k = 0; k < NUM_CH; k++) data[k*DATA_W +: DATA_W] = 5000;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    sample_valid = '0;
    model_reset();
    a = act_now();
    n_tests++;
    if (a !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL reset: outputs got %h expected 0", a);
    end
  endtask

  task automatic test_debounce();
    step_t s[$];
    exp_t  e, a;
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 3; i++) s.push_back(st(8'h01, 1200));
    s.push_back(st(8'h01, 900));
    for (int i = 0; i < 4; i++) s.push_back(st(8'h01, 1200));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL debounce step %0d: got %h expected %h", i, a, e);
      end
    end
    n_tests++;
    if (intl !== 1'b1 || intl_flag[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL debounce trip: flag0=%b intl=%b expected 1 1", intl_flag[0], intl);
    end
  endtask

  task automatic test_boundary();
    step_t s[$];
    exp_t  e, a;
    for (int i = 0; i < 4; i++) s.push_back(st(8'h01, -501));
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 8; i++) s.push_back(st(8'h01, -500));
    s.push_back(st(8'h01, 1000));
    for (int i = 0; i < 4; i++) s.push_back(st(8'h01, 1001));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL boundary step %0d: got %h expected %h", i, a, e);
      end
    end
  endtask

  task automatic test_gaps();
    step_t s[$];
    exp_t  e, a;
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      s.push_back(st(8'h01, 1200));
      for (int g = 0; g < 5; g++) s.push_back(st(8'h00, 0));
    end
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL gaps step %0d: got %h expected %h", i, a, e);
      end
    end
  endtask

  task automatic test_clear_priority();
    step_t s[$];
    exp_t  e, a;
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 3; i++) s.push_back(st(8'h01, 1200));
    s.push_back(st(8'h01, 1200, 1'b1));
    for (int i = 0; i < 4; i++) s.push_back(st(8'h01, 1200));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL clear_priority step %0d: got %h expected %h", i, a, e);
      end
    end
  endtask

  task automatic test_first_fault();
    step_t s[$];
    exp_t  e, a;
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 4; i++) s.push_back(st(8'h28, 1200));
    for (int i = 0; i < 4; i++) s.push_back(st(8'h02, 1200));
    s.push_back(st(8'h00, 0, 1'b1));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL first_fault step %0d: got %h expected %h", i, a, e);
      end
    end
  endtask

  task automatic test_ch_en();
    step_t s[$];
    exp_t  e, a;
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 3; i++) s.push_back(st(8'h04, 1200));
    s.push_back(st(8'h04, 0));
    for (int i = 0; i < 4; i++) s.push_back(st(8'h04, 1200));
    foreach (s[i]) begin
      ch_en = (i == 4) ? 8'hFB : 8'hFF;
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ch_en step %0d: got %h expected %h", i, a, e);
      end
    end
    ch_en = 8'hFF;
  endtask

  task automatic test_lo_gt_hi();
    step_t s[$];
    exp_t  e, a;
    hi_lim[7*DATA_W +: DATA_W] = -10;
    lo_lim[7*DATA_W +: DATA_W] = 10;
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 4; i++) s.push_back(st(8'h80, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL lo_gt_hi step %0d: got %h expected %h", i, a, e);
      end
    end
    hi_lim[7*DATA_W +: DATA_W] = 1000;
    lo_lim[7*DATA_W +: DATA_W] = -500;
  endtask

  task automatic test_reset_midcount();
    step_t s[$];
    exp_t  e, a;
    s.push_back(st(8'h00, 0, 1'b1));
    for (int i = 0; i < 3; i++) s.push_back(st(8'h01, 1200));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_mid pre step %0d: got %h expected %h", i, a, e);
      end
    end
    test_reset();
    s.delete();
    for (int i = 0; i < 4; i++) s.push_back(st(8'h01, 1200));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb.pop_front();
      a = act_now();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_mid post step %0d: got %h expected %h", i, a, e);
      end
    end
    n_tests++;
    if (intl_flag[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid trip: flag0=%b expected 1", intl_flag[0]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    intl_clr     = 1'b0;
    sample_valid = '0;
    ch_en        = '1;
    data         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hi_lim[k*DATA_W +: DATA_W] = 1000;
      lo_lim[k*DATA_W +: DATA_W] = -500;
    end
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_debounce();
    test_boundary();
    test_gaps();
    test_clear_priority();
    test_first_fault();
    test_ch_en();
    test_lo_gt_hi();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
